// File: rtl/sap_microsequencer_if.sv
// Bundles the SAP sequencer's datapath-facing signals: flags, opcode and memory status in, control word and status out.
// mem_ready acts as the memory's "valid": a T2/T4 read moves on only in a cycle where it is high; run gates the next fetch.
interface sap_microsequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                flag_carry;
  logic                flag_zero;
  logic                mem_ready;
  logic                run;
  logic [15:0]         ctrl;
  logic [2:0]          stage;
  logic                halted;
  logic                instr_done;
  logic [CNT_W-1:0]    retired_cnt;

  modport master (
    output opcode, flag_carry, flag_zero, mem_ready, run,
    input  ctrl, stage, halted, instr_done, retired_cnt
  );

  modport slave (
    input  opcode, flag_carry, flag_zero, mem_ready, run,
    output ctrl, stage, halted, instr_done, retired_cnt
  );
endinterface

// File: rtl/sap_microsequencer.sv
// Microcode sequencer for the 8-bit SAP CPU: T-state FSM producing the 16-bit control word,
// with variable-length instructions, conditional jumps, memory stalls, run/pause, HALT and a retired counter.
module sap_microsequencer #(
  parameter int OPCODE_W      = 4,
  parameter int CNT_W         = 16,
  parameter bit MEM_WAIT_EN   = 1'b1,
  parameter bit UNKNOWN_HALTS = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  sap_microsequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_T0 = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3,
    S_T4 = 3'd4, S_T5 = 3'd5, S_HOLD = 3'd6, S_HALT = 3'd7
  } state_t;

  localparam logic [15:0] CTRL_IDLE = 16'h0FE3;
  localparam int FLAGS_LOAD = 15, PC_INC = 14, PC_EN = 13, PC_LOAD = 12;
  localparam int MAR_ADDR_LOAD_N = 11, MAR_MEM_LOAD_N = 10, RAM_EN_N = 9, RAM_LOAD_N = 8;
  localparam int IR_LOAD_N = 7, IR_EN_N = 6, REGA_LOAD_N = 5, REGA_EN = 4;
  localparam int ADDER_SUB = 3, REGB_EN = 2, REGB_LOAD_N = 1, OUT_LOAD_N = 0;

  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0), OP_NOP = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2), OP_SUB = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4), OP_OUT = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(6), OP_JMP = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(8), OP_JZ  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_LIMIT = OPCODE_W'(10);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_retired;
  logic [15:0]         w_ctrl;
  logic                w_done;
  logic                w_mem_ok;
  logic [OPCODE_W-1:0] w_op;

  // Unknown opcodes are folded onto HLT or NOP so the decode below only sees known values.
  always_comb begin
    w_op = bus.opcode;
    if (bus.opcode >= OP_LIMIT) w_op = UNKNOWN_HALTS ? OP_HLT : OP_NOP;
  end

  assign w_mem_ok = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_HOLD;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = CTRL_IDLE;
    w_done = 1'b0;
    case (r_state)
      S_HOLD: if (bus.run) w_next = S_T0;
      S_T0: begin
        if (bus.run) begin
          w_ctrl[PC_EN]           = 1'b1;
          w_ctrl[MAR_ADDR_LOAD_N] = 1'b0;
          w_next                  = S_T1;
        end
      end
      S_T1: begin
        if (w_op != OP_HLT) w_ctrl[PC_INC] = 1'b1;
        w_next = S_T2;
      end
      S_T2: begin
        w_ctrl[RAM_EN_N] = 1'b0;
        if (w_mem_ok) begin
          w_ctrl[IR_LOAD_N] = 1'b0;
          w_next            = S_T3;
        end
      end
      S_T3: begin
        case (w_op)
          OP_HLT: w_next = S_HALT;
          OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
            w_ctrl[IR_EN_N]         = 1'b0;
            w_ctrl[MAR_ADDR_LOAD_N] = 1'b0;
            w_next                  = S_T4;
          end
          OP_OUT: begin
            w_ctrl[REGA_EN]    = 1'b1;
            w_ctrl[OUT_LOAD_N] = 1'b0;
            w_done             = 1'b1;
          end
          OP_JMP, OP_JC, OP_JZ: begin
            if (w_op == OP_JMP || (w_op == OP_JC && bus.flag_carry) ||
                (w_op == OP_JZ && bus.flag_zero)) begin
              w_ctrl[IR_EN_N] = 1'b0;
              w_ctrl[PC_LOAD] = 1'b1;
            end
            w_done = 1'b1;
          end
          default: w_done = 1'b1;
        endcase
      end
      S_T4: begin
        case (w_op)
          OP_ADD, OP_SUB: begin
            w_ctrl[RAM_EN_N] = 1'b0;
            if (w_mem_ok) begin
              w_ctrl[REGB_LOAD_N] = 1'b0;
              w_next              = S_T5;
            end
          end
          OP_LDA: begin
            w_ctrl[RAM_EN_N] = 1'b0;
            if (w_mem_ok) begin
              w_ctrl[REGA_LOAD_N] = 1'b0;
              w_done              = 1'b1;
            end
          end
          OP_STA: begin
            w_ctrl[REGA_EN]        = 1'b1;
            w_ctrl[MAR_MEM_LOAD_N] = 1'b0;
            w_next                 = S_T5;
          end
          default: w_next = S_T0;
        endcase
      end
      S_T5: begin
        case (w_op)
          OP_ADD, OP_SUB: begin
            w_ctrl[REGB_EN]     = 1'b1;
            w_ctrl[REGA_LOAD_N] = 1'b0;
            w_ctrl[FLAGS_LOAD]  = 1'b1;
            w_ctrl[ADDER_SUB]   = (w_op == OP_SUB);
            w_done              = 1'b1;
          end
          OP_STA: begin
            w_ctrl[RAM_LOAD_N] = 1'b0;
            w_done             = 1'b1;
          end
          default: w_next = S_T0;
        endcase
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_HOLD;
    endcase
    // Every completed instruction returns to T0.
    if (w_done) w_next = S_T0;
  end

  assign bus.ctrl        = w_ctrl;
  assign bus.stage       = r_state;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.instr_done  = w_done;
  assign bus.retired_cnt = r_retired;
endmodule

// File: tb/tb_sap_microsequencer.sv
// Directed bench for sap_microsequencer: walks each opcode through its T-states against hand-computed control words.
module tb_sap_microsequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sap_microsequencer_if #(.OPCODE_W(4), .CNT_W(16)) bus ();
  sap_microsequencer_if #(.OPCODE_W(4), .CNT_W(2))  bus2 ();

  sap_microsequencer #(.OPCODE_W(4), .CNT_W(16), .MEM_WAIT_EN(1'b1), .UNKNOWN_HALTS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  sap_microsequencer #(.OPCODE_W(4), .CNT_W(2), .MEM_WAIT_EN(1'b1), .UNKNOWN_HALTS(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Steps T0 -> T3 with mem_ready high.
  task automatic fetch();
    cyc(); cyc(); cyc();
  endtask

  task automatic exp_st(input string tag, input int st, input logic [15:0] ctrl, input logic done);
    chk({tag, "_stage"}, 32'(bus.stage), 32'(st));
    chk({tag, "_ctrl"}, 32'(bus.ctrl), 32'(ctrl));
    chk({tag, "_done"}, 32'(bus.instr_done), 32'(done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0; bus.opcode = 4'd0; bus.flag_carry = 1'b0; bus.flag_zero = 1'b0; bus.mem_ready = 1'b1;
    bus2.run = 1'b0; bus2.opcode = 4'd1; bus2.flag_carry = 1'b0; bus2.flag_zero = 1'b0; bus2.mem_ready = 1'b1;
    cyc(); cyc();
    chk("rst_stage", 32'(bus.stage), 32'd6);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_cnt", 32'(bus.retired_cnt), 32'd0);
    chk("rst_ctrl", 32'(bus.ctrl), 32'h0FE3);

    // ADD with no wait states
    rst_n = 1'b1; bus.run = 1'b1; bus.opcode = 4'd2;
    cyc(); exp_st("add_t0", 0, 16'h27E3, 1'b0);
    cyc(); exp_st("add_t1", 1, 16'h4FE3, 1'b0);
    cyc(); exp_st("add_t2", 2, 16'h0D63, 1'b0);
    cyc(); exp_st("add_t3", 3, 16'h07A3, 1'b0);
    cyc(); exp_st("add_t4", 4, 16'h0DE1, 1'b0);
    cyc(); exp_st("add_t5", 5, 16'h8FC7, 1'b1);
    chk("add_cnt_pre", 32'(bus.retired_cnt), 32'd0);
    cyc(); exp_st("add_end", 0, 16'h27E3, 1'b0);
    chk("add_cnt", 32'(bus.retired_cnt), 32'd1);

    // LDA then OUT
    bus.opcode = 4'd4; fetch(); exp_st("lda_t3", 3, 16'h07A3, 1'b0);
    cyc(); exp_st("lda_t4", 4, 16'h0DC3, 1'b1);
    cyc(); chk("lda_end", 32'(bus.stage), 32'd0);
    bus.opcode = 4'd5; fetch(); exp_st("out_t3", 3, 16'h0FF2, 1'b1);
    cyc(); chk("out_cnt", 32'(bus.retired_cnt), 32'd3);

    // Conditional jumps
    bus.opcode = 4'd9; fetch(); exp_st("jz0_t3", 3, 16'h0FE3, 1'b1); cyc();
    bus.flag_zero = 1'b1; fetch(); exp_st("jz1_t3", 3, 16'h1FA3, 1'b1); cyc();
    bus.flag_zero = 1'b0; bus.flag_carry = 1'b1; bus.opcode = 4'd8;
    fetch(); exp_st("jc1_t3", 3, 16'h1FA3, 1'b1); cyc();
    bus.flag_carry = 1'b0; fetch(); exp_st("jc0_t3", 3, 16'h0FE3, 1'b1); cyc();
    chk("jmp_cnt", 32'(bus.retired_cnt), 32'd7);

    // SUB with 3 wait cycles in T2 and 1 in T4
    bus.opcode = 4'd3; cyc(); cyc(); bus.mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      exp_st("t2_stall", 2, 16'h0DE3, 1'b0);
      cyc();
    end
    bus.mem_ready = 1'b1; #1; exp_st("t2_go", 2, 16'h0D63, 1'b0);
    cyc(); cyc(); bus.mem_ready = 1'b0; #1; exp_st("t4_stall", 4, 16'h0DE3, 1'b0);
    cyc(); exp_st("t4_stall2", 4, 16'h0DE3, 1'b0);
    bus.mem_ready = 1'b1; #1; exp_st("t4_go", 4, 16'h0DE1, 1'b0);
    cyc(); exp_st("sub_t5", 5, 16'h8FCF, 1'b1);
    cyc(); chk("sub_cnt", 32'(bus.retired_cnt), 32'd8);

    // STA and NOP
    bus.opcode = 4'd6; fetch(); cyc(); exp_st("sta_t4", 4, 16'h0BF3, 1'b0);
    cyc(); exp_st("sta_t5", 5, 16'h0EE3, 1'b1); cyc();
    bus.opcode = 4'd1; fetch(); exp_st("nop_t3", 3, 16'h0FE3, 1'b1); cyc();
    chk("nop_cnt", 32'(bus.retired_cnt), 32'd10);

    // run dropped mid-JMP: completes, then parks in T0
    bus.opcode = 4'd7; cyc(); bus.run = 1'b0; cyc(); cyc();
    exp_st("pause_t3", 3, 16'h1FA3, 1'b1);
    cyc(); exp_st("pause_t0a", 0, 16'h0FE3, 1'b0);
    cyc(); exp_st("pause_t0b", 0, 16'h0FE3, 1'b0);
    chk("pause_cnt", 32'(bus.retired_cnt), 32'd11);
    bus.run = 1'b1; #1; exp_st("resume_t0", 0, 16'h27E3, 1'b0);

    // Reset in ADD T4
    bus.opcode = 4'd2; fetch(); cyc(); chk("mid_t4", 32'(bus.stage), 32'd4);
    rst_n = 1'b0; cyc();
    chk("midrst_stage", 32'(bus.stage), 32'd6);
    chk("midrst_cnt", 32'(bus.retired_cnt), 32'd0);
    chk("midrst_ctrl", 32'(bus.ctrl), 32'h0FE3);
    rst_n = 1'b1; cyc(); chk("midrst_t0", 32'(bus.stage), 32'd0);

    // Unknown opcode behaves as NOP
    bus.opcode = 4'd12; cyc(); exp_st("unk_t1", 1, 16'h4FE3, 1'b0);
    cyc(); cyc(); exp_st("unk_t3", 3, 16'h0FE3, 1'b1);
    cyc(); chk("unk_cnt", 32'(bus.retired_cnt), 32'd1);

    // HLT: no PC_INC, enters HALT, ignores inputs
    bus.opcode = 4'd0; cyc(); exp_st("hlt_t1", 1, 16'h0FE3, 1'b0);
    cyc(); cyc(); exp_st("hlt_t3", 3, 16'h0FE3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.run = i[0]; bus.mem_ready = i[1]; bus.opcode = 4'(i);
      cyc();
      chk("halt_stage", 32'(bus.stage), 32'd7);
      chk("halt_flag", 32'(bus.halted), 32'd1);
      chk("halt_ctrl", 32'(bus.ctrl), 32'h0FE3);
    end
    chk("halt_cnt", 32'(bus.retired_cnt), 32'd1);

    // CNT_W=2 counter wrap over four NOPs
    bus.run = 1'b0; rst_n = 1'b0; cyc();
    bus2.run = 1'b1; rst_n = 1'b1; cyc();
    chk("wrap_t0", 32'(bus2.stage), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      repeat (4) cyc();
      chk("wrap_cnt", 32'(bus2.retired_cnt), 32'(k % 4));
    end
    chk("wrap_stage", 32'(bus2.stage), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
